// File: rtl/wb_frame_reader.sv
// rtl/wb_frame_reader.sv - Wishbone burst reader feeding a first-word-fall-through stream FIFO.
module wb_frame_reader #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int LW    = 16,
   parameter int DEPTH = 4
) (
   input  logic            wb_clk_i,
   input  logic            wb_reset_i,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [AW-1:0]   base_adr_i,
   input  logic [LW-1:0]   len_i,
   output logic [AW-1:0]   wb_adr_o,
   input  logic [DW-1:0]   wb_dat_i,
   output logic            wb_we_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   input  logic            wb_ack_i,
   output logic [DW-1:0]   px_data_o,
   output logic            px_valid_o,
   output logic            px_last_o,
   input  logic            px_ready_i,
   output logic            busy_o,
   output logic            done_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]       state;
   logic [AW-1:0]    adr;
   logic [LW-1:0]    remain;
   logic             done_q;
   logic [DW-1:0]    mem [DEPTH];
   logic [DEPTH-1:0] last_mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             push;
   logic             pop;

   // An ack arriving together with abort is dropped rather than stored.
   assign push = (state == S_FETCH) && wb_ack_i && !abort_i;
   assign pop  = px_valid_o && px_ready_i;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CW'(1);
      else if (!push && pop)
         count_next = count - CW'(1);
   end

   always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
      if (!wb_reset_i) begin
         state  <= S_IDLE;
         adr    <= '0;
         remain <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_i) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_i) begin
                     if (len_i != '0) begin
                        adr    <= base_adr_i;
                        remain <= len_i;
                        state  <= S_FETCH;
                     end else begin
                        done_q <= 1'b1;
                     end
                  end
               end
               S_FETCH: begin
                  if (wb_ack_i) begin
                     adr    <= adr + AW'(1);
                     remain <= remain - LW'(1);
                     // Keep the strobe up only if the next word is sure to fit.
                     if (remain == LW'(1))
                        state <= S_DRAIN;
                     else if (count_next >= CW'(DEPTH))
                        state <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (count < CW'(DEPTH))
                     state <= S_FETCH;
               end
               S_DRAIN: begin
                  if (pop && count == CW'(1)) begin
                     state  <= S_IDLE;
                     done_q <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
      if (!wb_reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (abort_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
      end
   end

   // Storage needs no reset: every read-side output is gated by occupancy.
   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         mem[wr_ptr]      <= wb_dat_i;
         last_mem[wr_ptr] <= (remain == LW'(1));
      end
   end

   assign px_valid_o = (count != '0);
   assign px_data_o  = px_valid_o ? mem[rd_ptr] : '0;
   assign px_last_o  = px_valid_o && last_mem[rd_ptr];

   assign wb_cyc_o = (state == S_FETCH);
   assign wb_stb_o = (state == S_FETCH);
   assign wb_adr_o = adr;
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = '1;
   assign busy_o   = (state != S_IDLE);
   assign done_o   = done_q;

endmodule

// File: doc/wb_frame_reader.md
WB_FRAME_READER -- requirements
Module: wb_frame_reader

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width and stream word width.
REQ-003 SHALL have parameter LW, default 16, transfer-length width in words.
REQ-004 SHALL have parameter DEPTH, default 4, output FIFO depth in words, a power of two and at least 2.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; no other clock or reset domains.
REQ-006 wb_clk_i  in  1  sole clock, rising edge.
REQ-007 wb_reset_i  in  1  asynchronous active-low reset.
REQ-008 start_i  in  1  one-cycle pulse that launches a transfer; ignored unless idle.
REQ-009 abort_i  in  1  cancels the current transfer.
REQ-010 base_adr_i  in  AW  first word address, sampled on an accepted start.
REQ-011 len_i  in  LW  word count, sampled on an accepted start.
REQ-012 wb_adr_o  out  AW  master address.
REQ-013 wb_dat_i  in  DW  read data.
REQ-014 wb_we_o  out  1  constant 0.
REQ-015 wb_sel_o  out  DW/8  constant all-ones.
REQ-016 wb_cyc_o, wb_stb_o  out  1 each  bus cycle and strobe.
REQ-017 wb_ack_i  in  1  slave acknowledge.
REQ-018 px_data_o  out  DW  stream data.
REQ-019 px_valid_o, px_last_o  out  1 each  stream valid, and final-word marker.
REQ-020 px_ready_i  in  1  stream ready.
REQ-021 busy_o  out  1  high in every state except IDLE.
REQ-022 done_o  out  1  one-cycle completion pulse.

Function
REQ-023 SHALL implement states IDLE, FETCH, HOLD, DRAIN.
REQ-024 IDLE + start_i, len_i>0: latch base and length; next cycle FETCH with wb_cyc_o=wb_stb_o=1 and wb_adr_o=base.
REQ-025 IDLE + start_i, len_i=0: stay IDLE, assert done_o the next cycle, no bus activity.
REQ-026 In FETCH, wb_adr_o and wb_stb_o SHALL be held stable until wb_ack_i.
REQ-027 On an ack edge, wb_dat_i SHALL be written into the FIFO, the address SHALL increment by 1 modulo 2^AW, and the remaining count SHALL decrement by 1.
REQ-028 After an ack, stb/cyc SHALL stay high with the new address only if words remain and post-edge FIFO occupancy is at most DEPTH-1; otherwise stb/cyc SHALL drop.
REQ-029 The block SHALL never have more than one outstanding request, and SHALL never request a word without guaranteed FIFO space.
REQ-030 FETCH -> HOLD when words remain and the FIFO is full; HOLD -> FETCH on the first cycle occupancy is below DEPTH.
REQ-031 FETCH -> DRAIN on the ack of the final word; DRAIN -> IDLE on the handshake of the final word, with done_o pulsing the cycle after.
REQ-032 The FIFO SHALL be first-word-fall-through: px_valid_o = FIFO non-empty, and px_data_o = head.
REQ-033 A handshake SHALL be px_valid_o & px_ready_i; it pops one word.
REQ-034 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-035 px_last_o SHALL be high only while the head is word len-1 of the transfer.
REQ-036 px_data_o SHALL hold stable while px_valid_o=1 and px_ready_i=0.
REQ-037 abort_i in any non-IDLE state: next cycle cyc/stb=0, FIFO flushed, IDLE, no done_o; any ack arriving in that cycle SHALL be discarded.
REQ-038 abort_i and start_i in the same cycle while IDLE: abort wins and the start is ignored.
REQ-039 start_i while busy SHALL be ignored.
REQ-040 Throughput SHALL be one word per two cycles against a slave that acks one cycle after strobe.

Reset
REQ-041 Reset asserted SHALL immediately force state IDLE.
REQ-042 Reset asserted SHALL immediately force wb_cyc_o=wb_stb_o=0 and wb_adr_o=0.
REQ-043 Reset asserted SHALL immediately force FIFO empty and px_valid_o=px_last_o=0, px_data_o=0.
REQ-044 Reset asserted SHALL immediately force busy_o=done_o=0.
REQ-045 Reset SHALL take effect mid-transfer with no completion pulse, and operation SHALL resume on the first clock edge after deassertion.

Verification
REQ-046 base=0x10, len=3, memory {A,B,C}, ready=1: addresses 0x10, 0x11, 0x12 each strobed until ack; stream A,B,C with last on C; done_o one cycle after C handshake; busy_o low after.
REQ-047 len=8, DEPTH=4, ready=0 for 20 cycles: exactly 4 acks, then cyc=0 (HOLD); on release the remaining 4 words are fetched, all 8 are streamed in order, and no request is made while full.
REQ-048 len=0: done_o pulses once, 1 cycle after start; cyc never asserted.
REQ-049 base=0xFFFFFFFF, len=2: second address is 0x00000000.
REQ-050 abort_i asserted on the cycle of the 2nd ack of len=6: cyc=0 next cycle; FIFO empty; no done_o; a following start with base=0x40 streams fresh data only.
REQ-051 Reset asserted while stb is high in FETCH: all outputs zero asynchronously; after release, start with len=1 completes normally.
